ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port `ram` between two requesters, typically the CPU core and a program/debug loader. It serialises their accesses, drives the RAM's `rw`/`addr`/`datain` pins, and returns read data with a per-requester completion pulse. Each transaction is atomic, one is outstanding at a time, and each takes three clock cycles.

---
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// One atomic transaction at a time: grant, RAM access, response (3 cycles).
module ram_arbiter #(
  parameter int data_width = 4,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [data_width-1:0] rdata,
  output logic                  busy,
  output logic                  mem_rw,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_datain,
  input  logic [data_width-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   owner;
  logic   wr_q;
  logic   any_req;
  logic   sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_req   = req0 | req1;
    sel       = (req0 & req1) ? ~last : req1;
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= '0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= sel;
            gnt0       <= ~sel;
            gnt1       <= sel;
            mem_addr   <= sel ? addr1  : addr0;
            mem_rw     <= sel ? we1    : we0;
            mem_datain <= sel ? wdata1 : wdata0;
            wr_q       <= sel ? we1    : we0;
          end else begin
            mem_rw <= 1'b0;
          end
        end
        // Write strobe is dropped here so it is exactly one cycle wide.
        ACCESS: mem_rw <= 1'b0;
        RESP: begin
          done0 <= ~owner;
          done1 <= owner;
          if (!wr_q) rdata <= mem_dataout;
          last  <= owner;
        end
        default: ;
      endcase
    end
  end

  // The completion cycle still belongs to the transaction.
  assign busy = (state != IDLE) | done0 | done1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and
// a transaction-level reference model of arbitration and memory contents.
module tb_ram_arbiter;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, busy, mem_rw;
  logic [DW-1:0] rdata, mem_datain, mem_dataout;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic preload = 1'b0;
  int unsigned seed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 5 + int'(seed)) ^ (int'(seed) >> 4));
  endfunction

  // Single-port RAM: registered read, write committed on the edge rw is seen.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
    end else begin
      if (mem_rw) ram[mem_addr] <= mem_datain;
      mem_dataout <= ram[mem_addr];
    end
  end

  // Reference model: transactions are serial, 3 cycles each, ties alternate.
  typedef struct {
    int            cyc;
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;
  typedef struct {
    int            cyc;
    int            who;
    logic [DW-1:0] rd;
  } done_t;

  gnt_t          gq[$];
  done_t         dq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0, free_at = 0, m_last = 1, p_who = 0, pw_cyc = -1;
  logic [AW-1:0] pw_addr = '0;
  logic [DW-1:0] pw_data = '0, m_rd = '0;
  gnt_t          pg;
  done_t         pd;

  always @(posedge clk) begin
    cyc++;
    if (preload) for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    if (rst) begin
      gq.delete();
      dq.delete();
      free_at = 0;
      m_last  = 1;
      m_rd    = '0;
      pw_cyc  = -1;
    end else begin
      if (pw_cyc == cyc) ref_mem[pw_addr] = pw_data;
      if (cyc >= free_at && (req0 || req1)) begin
        p_who    = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
        pg.cyc   = cyc;
        pg.who   = p_who;
        pg.we    = p_who == 1 ? we1 : we0;
        pg.addr  = p_who == 1 ? addr1 : addr0;
        pg.wdata = p_who == 1 ? wdata1 : wdata0;
        gq.push_back(pg);
        if (pg.we) begin
          pw_cyc  = cyc + 1;
          pw_addr = pg.addr;
          pw_data = pg.wdata;
        end else begin
          m_rd = ref_mem[pg.addr];
        end
        pd.cyc = cyc + 2;
        pd.who = p_who;
        pd.rd  = m_rd;
        dq.push_back(pd);
        m_last  = p_who;
        free_at = cyc + 3;
      end
    end
  end

  // Monitor: compare DUT outputs to the front of the expectation queues.
  gnt_t  mg;
  done_t md;
  always @(negedge clk) begin
    if (chk_en) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        mg = gq.pop_front();
        chk("gnt0", int'(gnt0), int'(mg.who == 0));
        chk("gnt1", int'(gnt1), int'(mg.who == 1));
        chk("mem_rw", int'(mem_rw), int'(mg.we));
        chk("mem_addr", int'(mem_addr), int'(mg.addr));
        chk("mem_datain", int'(mem_datain), int'(mg.wdata));
      end else begin
        chk("gnt0_quiet", int'(gnt0), 0);
        chk("gnt1_quiet", int'(gnt1), 0);
        chk("mem_rw_quiet", int'(mem_rw), 0);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        md = dq.pop_front();
        chk("done0", int'(done0), int'(md.who == 0));
        chk("done1", int'(done1), int'(md.who == 1));
        chk("rdata", int'(rdata), int'(md.rd));
      end else begin
        chk("done0_quiet", int'(done0), 0);
        chk("done1_quiet", int'(done1), 0);
      end
      chk("busy", int'(busy), int'(cyc < free_at));
    end
  end

  task automatic chk_reset_outs(input string p);
    chk({p, "_gnt0"}, int'(gnt0), 0);
    chk({p, "_gnt1"}, int'(gnt1), 0);
    chk({p, "_done0"}, int'(done0), 0);
    chk({p, "_done1"}, int'(done1), 0);
    chk({p, "_rdata"}, int'(rdata), 0);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_mem_rw"}, int'(mem_rw), 0);
    chk({p, "_mem_addr"}, int'(mem_addr), 0);
    chk({p, "_mem_datain"}, int'(mem_datain), 0);
  endtask

  task automatic new_txn(input int n);
    if (n == 0) begin
      req0 = 1'b1; we0 = ($urandom_range(0, 2) == 0);
      addr0 = AW'($urandom); wdata0 = DW'($urandom);
    end else begin
      req1 = 1'b1; we1 = ($urandom_range(0, 2) == 0);
      addr1 = AW'($urandom); wdata1 = DW'($urandom);
    end
  endtask

  int idle [2];

  task automatic drive_step();
    logic r, g;
    for (int n = 0; n < 2; n++) begin
      r = (n == 0) ? req0 : req1;
      g = (n == 0) ? gnt0 : gnt1;
      if (r && g) begin
        if ($urandom_range(0, 1) == 1) begin
          new_txn(n);
        end else begin
          // Scramble the fields right after the grant; they must be ignored.
          new_txn(n);
          if (n == 0) req0 = 1'b0; else req1 = 1'b0;
          idle[n] = $urandom_range(0, 3);
        end
      end else if (!r) begin
        if (idle[n] == 0) new_txn(n);
        else idle[n]--;
      end
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 12; i++) begin
      if (gq.size() == 0 && dq.size() == 0 && cyc >= free_at) break;
      @(negedge clk);
    end
    chk(nm, gq.size() + dq.size(), 0);
  endtask

  task automatic wait_gnt(input int n, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = (n == 0) ? gnt0 : gnt1;
    end
    chk(nm, int'(seen), 1);
  endtask

  initial begin
    seed    = $urandom;
    rst     = 1'b1;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Both requesting on the first sample: requester 0 must win the tie.
    new_txn(0);
    new_txn(1);
    idle[0] = 0;
    idle[1] = 0;
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      drive_step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain("drain_random");

    // Known value at addr 2, then a write to it aborted by reset in ACCESS.
    req1 = 1'b1; we1 = 1'b1; addr1 = AW'(2); wdata1 = DW'(5);
    wait_gnt(1, "gnt1_setup");
    req1 = 1'b0;
    drain("drain_setup");

    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(2); wdata0 = DW'(15);
    wait_gnt(0, "gnt0_abort");
    req0 = 1'b0;
    #2;
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    chk("abort_no_commit", int'(ram[2]), int'(ref_mem[2]));
    chk("abort_ram2", int'(ram[2]), 5);
    @(negedge clk);
    chk("midrst_no_done", int'(done0), 0);
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(2);
    rst    = 1'b0;
    chk_en = 1'b1;
    wait_gnt(1, "gnt1_after_rst");
    req1 = 1'b0;
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors %0d)", n_err);
    $fatal(1);
  end

endmodule
